// File: rtl/clock_set_ctrl.sv
// Mode/timing controller for the 24-hour clock counter chain: 1 Hz enable, button-driven time
// setting (NORMAL -> SET_HOUR -> SET_MIN) and digit blinking. Optional: CLOCK_SET_AUTOREP_EN.
module clock_set_ctrl #(
    parameter int unsigned PRESCALE    = 50000000,
    parameter int unsigned BLINK_DIV   = 12500000,
    parameter int unsigned REPEAT_DLY  = 25000000,
    parameter int unsigned REPEAT_RATE = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    output logic       sec_en,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned BW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        StNormal  = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10,
        StInvalid = 2'b11
    } mode_e;

    mode_e          mode_q, mode_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           phase_q, phase_d;
    logic           btn_mode_q, btn_set_q;
    logic           sec_en_q, sec_en_d;
    logic           min_inc_q, min_inc_d;
    logic           hour_inc_q, hour_inc_d;
    logic           sec_clr_q, sec_clr_d;
    logic           blank_hour_q, blank_hour_d;
    logic           blank_min_q, blank_min_d;
    logic           mode_press, set_press, stay_set;

`ifdef CLOCK_SET_AUTOREP_EN
    localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
    logic           rep_run_q, rep_run_d;
    logic           rep_act_q, rep_act_d;
    logic           rep_fire;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q       <= StNormal;
            presc_q      <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            // Held-through-reset buttons must be released before they count as a press.
            btn_mode_q   <= 1'b1;
            btn_set_q    <= 1'b1;
            sec_en_q     <= 1'b0;
            min_inc_q    <= 1'b0;
            hour_inc_q   <= 1'b0;
            sec_clr_q    <= 1'b0;
            blank_hour_q <= 1'b0;
            blank_min_q  <= 1'b0;
`ifdef CLOCK_SET_AUTOREP_EN
            rep_cnt_q    <= '0;
            rep_run_q    <= 1'b0;
            rep_act_q    <= 1'b0;
`endif
        end else begin
            mode_q       <= mode_d;
            presc_q      <= presc_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            btn_mode_q   <= btn_mode;
            btn_set_q    <= btn_set;
            sec_en_q     <= sec_en_d;
            min_inc_q    <= min_inc_d;
            hour_inc_q   <= hour_inc_d;
            sec_clr_q    <= sec_clr_d;
            blank_hour_q <= blank_hour_d;
            blank_min_q  <= blank_min_d;
`ifdef CLOCK_SET_AUTOREP_EN
            rep_cnt_q    <= rep_cnt_d;
            rep_run_q    <= rep_run_d;
            rep_act_q    <= rep_act_d;
`endif
        end
    end

    always_comb begin
        mode_press  = btn_mode & ~btn_mode_q;
        set_press   = btn_set & ~btn_set_q;
        mode_d      = mode_q;
        presc_d     = '0;
        sec_en_d    = 1'b0;
        min_inc_d   = 1'b0;
        hour_inc_d  = 1'b0;
        sec_clr_d   = 1'b0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        stay_set    = 1'b0;

        case (mode_q)
            StNormal: begin
                if (mode_press) begin
                    mode_d = StSetHour;
                end else begin
                    sec_en_d = (presc_q == PW'(PRESCALE - 1));
                    presc_d  = sec_en_d ? '0 : presc_q + PW'(1);
                end
            end
            StSetHour: begin
                if (mode_press) mode_d = StSetMin;
                else begin
                    stay_set   = 1'b1;
                    hour_inc_d = set_press;
                end
            end
            StSetMin: begin
                if (mode_press) begin
                    mode_d    = StNormal;
                    sec_clr_d = 1'b1;
                end else begin
                    stay_set  = 1'b1;
                    min_inc_d = set_press;
                end
            end
            default: mode_d = StNormal;
        endcase

        // Entering a set mode (or leaving one) restarts the blink with digits visible.
        if (stay_set) begin
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                phase_d     = phase_q;
            end
        end

`ifdef CLOCK_SET_AUTOREP_EN
        rep_cnt_d = '0;
        rep_run_d = 1'b0;
        rep_act_d = 1'b0;
        rep_fire  = 1'b0;
        if (stay_set && set_press) begin
            rep_run_d = 1'b1;
            rep_cnt_d = RW'(1);
        end else if (stay_set && rep_run_q && btn_set) begin
            rep_run_d = 1'b1;
            rep_fire  = rep_act_q ? (rep_cnt_q == RW'(REPEAT_RATE - 1))
                                  : (rep_cnt_q == RW'(REPEAT_DLY - 1));
            rep_act_d = rep_act_q | rep_fire;
            rep_cnt_d = rep_fire ? '0 : rep_cnt_q + RW'(1);
        end
        if (rep_fire) begin
            hour_inc_d = (mode_q == StSetHour);
            min_inc_d  = (mode_q == StSetMin);
        end
        // Keep the digits visible while the value is auto-stepping.
        if (rep_act_d) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end
`endif

        blank_hour_d = (mode_d == StSetHour) & phase_d;
        blank_min_d  = (mode_d == StSetMin) & phase_d;
    end

    assign sec_en     = sec_en_q;
    assign min_inc    = min_inc_q;
    assign hour_inc   = hour_inc_q;
    assign sec_clr    = sec_clr_q;
    assign mode       = mode_q;
    assign blank_hour = blank_hour_q;
    assign blank_min  = blank_min_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random button activity, every cycle compared
// against a time-based model (elapsed cycles per mode, press/hold counts).
module tb_clock_set_ctrl;

    localparam int unsigned PRESCALE    = 10;
    localparam int unsigned BLINK_DIV   = 4;
    localparam int unsigned REPEAT_DLY  = 8;
    localparam int unsigned REPEAT_RATE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_set = 1'b0;
    logic       sec_en, min_inc, hour_inc, sec_clr, blank_hour, blank_min;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    // Model state: mode, cycles since NORMAL (re)start, cycles since blink restart, set hold time.
    int m_mode, t_norm, elapsed, hold;
    bit prev_m, prev_s;
    bit e_sec, e_min, e_hour, e_clr, e_bh, e_bm;

    clock_set_ctrl #(
        .PRESCALE   (PRESCALE),
        .BLINK_DIV  (BLINK_DIV),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_RATE(REPEAT_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_set   (btn_set),
        .sec_en    (sec_en),
        .min_inc   (min_inc),
        .hour_inc  (hour_inc),
        .sec_clr   (sec_clr),
        .mode      (mode),
        .blank_hour(blank_hour),
        .blank_min (blank_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; t_norm = 0; elapsed = 0; hold = 0;
        prev_m = 1'b1; prev_s = 1'b1;
        {e_sec, e_min, e_hour, e_clr, e_bh, e_bm} = '0;
    endtask

    task automatic model_edge(input bit bm, input bit bs);
        bit mp, sp, inc, phase;
        mp = bm & ~prev_m;
        sp = bs & ~prev_s;
        prev_m = bm;
        prev_s = bs;
        inc = 1'b0;
        {e_sec, e_min, e_hour, e_clr} = '0;
        if (mp) begin
            e_clr  = (m_mode == 2);
            m_mode = (m_mode + 1) % 3;
            t_norm = 0; elapsed = 0; hold = 0;
        end else if (m_mode == 0) begin
            t_norm++;
            e_sec = (t_norm % PRESCALE == 0);
            hold  = 0;
        end else begin
            elapsed++;
            inc = sp;
`ifdef CLOCK_SET_AUTOREP_EN
            if (sp) hold = 1;
            else if (hold > 0 && bs) begin
                hold++;
                if (hold >= REPEAT_DLY && (hold - REPEAT_DLY) % REPEAT_RATE == 0) inc = 1'b1;
            end else hold = 0;
            if (hold >= REPEAT_DLY) elapsed = 0;
`endif
            e_hour = inc && (m_mode == 1);
            e_min  = inc && (m_mode == 2);
        end
        phase = (m_mode != 0) && ((elapsed / BLINK_DIV) % 2 == 1);
        e_bh  = (m_mode == 1) && phase;
        e_bm  = (m_mode == 2) && phase;
    endtask

    // One clock edge with the given rst/buttons, then compare all outputs 1 time unit later.
    task automatic step(input bit r, input bit bm, input bit bs);
        rst = r; btn_mode = bm; btn_set = bs;
        @(posedge clk);
        if (!r) model_reset();
        else model_edge(bm, bs);
        #1;
        chk("sec_en", {1'b0, sec_en}, {1'b0, e_sec});
        chk("min_inc", {1'b0, min_inc}, {1'b0, e_min});
        chk("hour_inc", {1'b0, hour_inc}, {1'b0, e_hour});
        chk("sec_clr", {1'b0, sec_clr}, {1'b0, e_clr});
        chk("mode", mode, 2'(m_mode));
        chk("blank_hour", {1'b0, blank_hour}, {1'b0, e_bh});
        chk("blank_min", {1'b0, blank_min}, {1'b0, e_bm});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_set();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_mode();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int bm, bs, dur;
        model_reset();
        // Plain reset, free-running seconds.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        idle(35);
        // Mode button held through reset is ignored until pressed again.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 1'b0);
        chk("mode_after_repress", mode, 2'b01);
        step(1'b1, 1'b0, 1'b0);
        // Hours x3, minutes x2, back to NORMAL with sec_clr and restarted prescaler.
        for (int i = 0; i < 3; i++) press_set();
        press_mode();
        for (int i = 0; i < 2; i++) press_set();
        press_mode();
        idle(22);
        // Simultaneous mode and set press in SET_HOUR after some blinking.
        press_mode();
        idle(12);
        step(1'b1, 1'b1, 1'b1);
        chk("simul_mode", mode, 2'b10);
        step(1'b1, 1'b0, 1'b0);
        press_mode();
        idle(5);
        // Set presses in NORMAL do nothing.
        for (int i = 0; i < 4; i++) press_set();
        idle(12);
        // Long set hold in SET_MIN (auto-repeat when enabled).
        press_mode();
        press_mode();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
        idle(10);
        press_mode();
        idle(3);
        // Random button activity with occasional resets.
        for (int k = 0; k < 150; k++) begin
            bm  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            bs  = $urandom_range(0, 1);
            dur = $urandom_range(1, 25);
            for (int i = 0; i < dur; i++) step(($urandom_range(0, 199) != 0), bm[0], bs[0]);
            idle($urandom_range(0, 3));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Mode and timing controller for the 24-hour clock counter chain (second, minute and hour counters).
- Generates the 1 Hz run enable from the system clock.
- Sequences time-setting through two push buttons: NORMAL -> SET_HOUR -> SET_MIN.
- Drives the counters' increment inputs and the display blanking signals for the digits being set.

Parameters:
- PRESCALE, 50000000: clk cycles per second tick; legal range 2 or more.
- BLINK_DIV, 12500000: clk cycles per blink phase in set modes; legal range 2 or more.
- REPEAT_DLY, 25000000: hold cycles before auto-repeat starts (AUTOREP_EN only).
- REPEAT_RATE, 5000000: cycles between auto-repeat pulses (AUTOREP_EN only).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising clk edge resets the block.
- btn_mode  in  1  mode button; already synchronised and debounced; 1 = pressed.
- btn_set  in  1  set button; already synchronised and debounced; 1 = pressed.
- sec_en  out  1  one-cycle pulse per second; drives the second counter's enin.
- min_inc  out  1  one-cycle increment pulse to the minute counter's inc.
- hour_inc  out  1  one-cycle increment pulse to the hour counter's inc.
- sec_clr  out  1  one-cycle clear of the second counter on leaving SET_MIN.
- mode  out  2  00 NORMAL, 01 SET_HOUR, 10 SET_MIN.
- blank_hour  out  1  1 = blank the hour digits this cycle.
- blank_min  out  1  1 = blank the minute digits this cycle.

Behaviour:
- Reset (rst==0 at an edge):
  - mode=00; sec_en, min_inc, hour_inc, sec_clr = 0; blank_hour, blank_min = 0.
  - Prescaler = 0; blink counter = 0, phase = 0.
  - Button history registers = 1, so a button held through reset is ignored until it is released and pressed again.
- Press detection: press = btn & ~btn_q, with btn_q registered every cycle. A press is one cycle per 0->1 transition.
- All outputs are registered. Any pulse caused by a press sampled at edge N is high during the cycle after edge N (latency 1) and lasts exactly one cycle.
- Prescaler in NORMAL:
  - Counts 0..PRESCALE-1 and wraps.
  - sec_en=1 for the cycle following the edge where the count is PRESCALE-1.
  - First sec_en comes PRESCALE cycles after reset release.
- Prescaler in set modes:
  - Held at 0; sec_en=0.
  - On return to NORMAL it restarts from 0, so the first sec_en comes PRESCALE cycles after the mode change.
- FSM, mode press transitions:
  - NORMAL -> SET_HOUR.
  - SET_HOUR -> SET_MIN.
  - SET_MIN -> NORMAL, with sec_clr pulsed on the same edge as the mode change.
  - Encoding 11 is unreachable; if it is ever entered, the next edge moves to NORMAL with no pulses.
- Set press handling:
  - SET_HOUR: hour_inc pulse.
  - SET_MIN: min_inc pulse.
  - NORMAL: ignored.
- Simultaneous mode and set presses in one cycle: mode wins and the set press is discarded.
- Blink:
  - On entry to any set mode, the blink counter and phase are set to 0 (digits visible).
  - The phase toggles every BLINK_DIV cycles while in a set mode.
  - blank_hour = (mode==01) & phase; blank_min = (mode==10) & phase.
  - In NORMAL, both blanks are 0.
- sec_en, min_inc and hour_inc are never high in the same cycle as a mode change.
- Counters wrap on their own: 23 -> 0 for hours, 59 -> 0 for minutes. The controller applies no saturation.

Optional Feature:
- Macro: CLOCK_SET_AUTOREP_EN.
- Defined:
  - While in a set mode and btn_set is held continuously, a repeat counter starts at the press.
  - After REPEAT_DLY cycles held, an extra inc pulse is issued, then one every REPEAT_RATE cycles.
  - Releasing the button, a mode change or reset clears the repeat counter.
  - The blink phase is forced to 0 while repeat pulses are issued.
- Undefined: exactly one inc pulse per press; no repeat logic is synthesised.

Test Plan (PRESCALE=10, BLINK_DIV=4, REPEAT_DLY=8, REPEAT_RATE=3):
- Release rst with both buttons low -> sec_en pulses at cycles 10, 20, 30 after release; mode=00; no other pulses.
- Hold btn_mode high through reset, then release and press again -> no transition during the hold; mode=01 one cycle after the second rising edge.
- Mode press, 3 set presses, mode press, 2 set presses, mode press -> 3 hour_inc pulses, 2 min_inc pulses, and one sec_clr pulse on returning to 00; sec_en first reasserts 10 cycles later.
- In SET_HOUR, assert btn_mode and btn_set rising on the same edge -> mode=10 and no hour_inc; blank_hour toggles with period 8 cycles before the press and both blanks are 0 right after.
- Set press in NORMAL -> no inc pulses; prescaler phase undisturbed (sec_en still every 10 cycles).
- With CLOCK_SET_AUTOREP_EN, hold btn_set 20 cycles in SET_MIN -> min_inc at press+1, then at press+8, +11, +14, +17, +20; none after release.
